// File: rtl/nic_tracked.sv
// nic_tracked: single-master to N-slave interconnect with one tracked
// outstanding transaction.
//
// A request is accepted in IDLE, or in the same cycle a pending transaction
// is acked, which allows back-to-back accesses with no bubble. The accepted
// slave index is latched. Only that slave's ack and data are returned.
// Out-of-range indices receive an error response one cycle after the request.
//
// Optional feature macro: NIC_TIMEOUT_EN
//   Defined   : a WAIT that lasts TIMEOUT_CYCLES cycles ends with an error response.
//   Undefined : no timeout counter is built, and WAIT lasts until the slave acks.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset; all outputs forced to 0 while low
//   i_nic_sel    master request valid
//   i_addr_sel   target slave index
//   o_busy       request not accepted this cycle
//   o_slave_sel  one-hot slave select pulse for an accepted in-range request
//   i_rdata      per-slave read data, packed [slave][bit]
//   i_ack        per-slave ack
//   o_rdata      response data (0 unless o_ack)
//   o_ack        response strobe
//   o_err        error qualifier for o_ack
//   o_err_cnt    saturating count of error responses
//
// States:
//   IDLE | no transaction outstanding
//   WAIT | waiting for ack from slave r_idx
//   ERR  | emit error response for one cycle
module nic_tracked #(
    parameter int ADDR_SEL_WIDTH = 2,
    parameter int SLAVES_COUNT   = 2**ADDR_SEL_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_nic_sel,
    input  logic [ADDR_SEL_WIDTH-1:0]              i_addr_sel,
    output logic                                   o_busy,
    output logic [SLAVES_COUNT-1:0]                o_slave_sel,
    input  logic [SLAVES_COUNT-1:0][DATA_WIDTH-1:0] i_rdata,
    input  logic [SLAVES_COUNT-1:0]                i_ack,
    output logic [DATA_WIDTH-1:0]                  o_rdata,
    output logic                                   o_ack,
    output logic                                   o_err,
    output logic [ERR_CNT_WIDTH-1:0]               o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_SEL_WIDTH-1:0] r_idx;
    logic [ERR_CNT_WIDTH-1:0]  r_err_cnt;

    logic                      w_hit;
    logic [DATA_WIDTH-1:0]     w_hit_data;
    logic [SLAVES_COUNT-1:0]   w_sel_dec;
    logic                      w_in_range;
    logic                      w_can_accept;
    logic                      w_accept_ok;
    logic                      w_accept_err;
    logic                      w_timeout;

    // Ack/data from the latched slave only. Other slaves' acks are never looked at.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int s = 0; s < SLAVES_COUNT; s++) begin
            if (r_idx == ADDR_SEL_WIDTH'(s)) begin
                w_hit      = i_ack[s];
                w_hit_data = i_rdata[s];
            end
        end
        w_hit = w_hit && (r_state == S_WAIT);
    end

    always_comb begin
        w_sel_dec = '0;
        for (int s = 0; s < SLAVES_COUNT; s++) begin
            if (i_addr_sel == ADDR_SEL_WIDTH'(s)) begin
                w_sel_dec[s] = 1'b1;
            end
        end
    end

    assign w_in_range   = ({1'b0, i_addr_sel} < (ADDR_SEL_WIDTH+1)'(SLAVES_COUNT));
    // A request can be taken in IDLE, or in the cycle that a pending access completes.
    assign w_can_accept = i_rst_n && ((r_state == S_IDLE) || w_hit);
    assign w_accept_ok  = w_can_accept && i_nic_sel && w_in_range;
    assign w_accept_err = w_can_accept && i_nic_sel && !w_in_range;

`ifdef NIC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_accept_ok) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_WAIT) && !w_hit && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register plus latched index and error counter
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept_ok) begin
                r_idx <= i_addr_sel;
            end
            if ((r_state == S_ERR) && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept_ok) begin
            w_state_nxt = S_WAIT;
        end else if (w_accept_err) begin
            w_state_nxt = S_ERR;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_WAIT: begin
                    if (w_hit) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_timeout) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_ERR:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic. Reset forces everything low, including combinational paths.
    always_comb begin
        o_busy      = 1'b0;
        o_slave_sel = '0;
        o_rdata     = '0;
        o_ack       = 1'b0;
        o_err       = 1'b0;
        o_err_cnt   = '0;
        if (i_rst_n) begin
            o_err_cnt = r_err_cnt;
            if (w_accept_ok) begin
                o_slave_sel = w_sel_dec;
            end
            case (r_state)
                S_WAIT: begin
                    o_busy = !w_hit;
                    if (w_hit) begin
                        o_ack   = 1'b1;
                        o_rdata = w_hit_data;
                    end
                end
                S_ERR: begin
                    o_busy = 1'b1;
                    o_ack  = 1'b1;
                    o_err  = 1'b1;
                end
                default: o_busy = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_tracked.sv
module tb_nic_tracked;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             nic_sel, nic_sel3;
    logic [1:0]       addr_sel, addr_sel3;
    logic [3:0][31:0] rdata;
    logic [3:0]       ack;

    logic        o_busy, o_ack, o_err;
    logic [3:0]  o_slave_sel;
    logic [31:0] o_rdata;
    logic [7:0]  o_err_cnt;

    logic        o_busy3, o_ack3, o_err3;
    logic [2:0]  o_slave_sel3;
    logic [31:0] o_rdata3;
    logic [7:0]  o_err_cnt3;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt0 = 0;
    int exp_cnt3 = 0;

    logic [32:0] q0[$];
    logic [32:0] q3[$];

    always #5 clk = ~clk;

    nic_tracked dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_nic_sel(nic_sel), .i_addr_sel(addr_sel),
        .o_busy(o_busy), .o_slave_sel(o_slave_sel), .i_rdata(rdata), .i_ack(ack),
        .o_rdata(o_rdata), .o_ack(o_ack), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    nic_tracked #(.SLAVES_COUNT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_nic_sel(nic_sel3), .i_addr_sel(addr_sel3),
        .o_busy(o_busy3), .o_slave_sel(o_slave_sel3), .i_rdata(rdata[2:0]), .i_ack(ack[2:0]),
        .o_rdata(o_rdata3), .o_ack(o_ack3), .o_err(o_err3), .o_err_cnt(o_err_cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Response monitors: every ack must match the head of its scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        if (o_ack) begin
            if (q0.size() == 0) begin
                chk("dut_unexpected_ack", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("dut_err", o_err, e[32]);
                chk("dut_rdata", o_rdata, e[31:0]);
            end
        end else begin
            chk("dut_rdata_zero", o_rdata, 0);
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (o_ack3) begin
            if (q3.size() == 0) begin
                chk("dut3_unexpected_ack", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("dut3_err", o_err3, e[32]);
                chk("dut3_rdata", o_rdata3, e[31:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; nic_sel = 1'b1; addr_sel = 2'd1;
        nic_sel3 = 1'b0; addr_sel3 = 2'd0;
        rdata = '0; ack = '0;

        // Reset with a request held
        smp();
        chk("rst_sel", o_slave_sel, 0);
        chk("rst_ack", o_ack, 0);
        chk("rst_busy", o_busy, 0);
        cyc(); cyc(); smp();
        chk("rst_sel2", o_slave_sel, 0);
        chk("rst_errcnt", o_err_cnt, 0);
        cyc(); rst_n = 1'b1; nic_sel = 1'b0;

        // Basic read of slave 2, ack at cycle 3
        cyc(); nic_sel = 1'b1; addr_sel = 2'd2; smp();
        chk("rd_sel_c0", o_slave_sel, 4'b0100);
        chk("rd_busy_c0", o_busy, 0);
        cyc(); nic_sel = 1'b0; smp();
        chk("rd_sel_c1", o_slave_sel, 0);
        chk("rd_busy_c1", o_busy, 1);
        cyc(); smp();
        chk("rd_busy_c2", o_busy, 1);
        cyc(); ack[2] = 1'b1; rdata[2] = 32'hDEADBEEF; q0.push_back({1'b0, 32'hDEADBEEF}); smp();
        chk("rd_ack_c3", o_ack, 1);
        chk("rd_busy_c3", o_busy, 0);
        cyc(); ack = '0; smp();
        chk("rd_ack_c4", o_ack, 0);

        // Ack in the select cycle is ignored; earliest ack is the next cycle
        cyc(); nic_sel = 1'b1; addr_sel = 2'd1; ack[1] = 1'b1; rdata[1] = 32'h0BAD0BAD; smp();
        chk("minlat_noack_c0", o_ack, 0);
        cyc(); nic_sel = 1'b0; rdata[1] = 32'h12345678; q0.push_back({1'b0, 32'h12345678}); smp();
        chk("minlat_ack_c1", o_ack, 1);
        cyc(); ack = '0; smp();

        // Back-to-back, stray acks, and a request held while busy
        cyc(); nic_sel = 1'b1; addr_sel = 2'd0; smp();
        chk("b2b_sel0", o_slave_sel, 4'b0001);
        cyc(); addr_sel = 2'd3; ack[0] = 1'b1; rdata[0] = 32'h11111111;
        q0.push_back({1'b0, 32'h11111111}); smp();
        chk("b2b_sel3", o_slave_sel, 4'b1000);
        chk("b2b_busy", o_busy, 0);
        cyc(); ack = '0; ack[1] = 1'b1; rdata[1] = 32'hBADBAD00; addr_sel = 2'd1; smp();
        chk("stray_noack", o_ack, 0);
        chk("held_busy", o_busy, 1);
        chk("held_nosel", o_slave_sel, 0);
        cyc(); ack = '0; ack[3] = 1'b1; rdata[3] = 32'h33333333;
        q0.push_back({1'b0, 32'h33333333}); smp();
        chk("held_sel1", o_slave_sel, 4'b0010);
        cyc(); nic_sel = 1'b0; ack = '0; smp();
        chk("b2b_wait_busy", o_busy, 1);
        cyc(); ack[1] = 1'b1; rdata[1] = 32'h55AA55AA; q0.push_back({1'b0, 32'h55AA55AA}); smp();
        chk("b2b_last_ack", o_ack, 1);
        cyc(); ack = '0; smp();
        chk("b2b_idle_busy", o_busy, 0);

`ifdef NIC_TIMEOUT_EN
        // Timeout: error response TIMEOUT_CYCLES+1 cycles after the select
        for (int r = 0; r < 3; r++) begin
            cyc(); nic_sel = 1'b1; addr_sel = 2'd1; q0.push_back({1'b1, 32'h0}); smp();
            chk("tmo_sel", o_slave_sel, 4'b0010);
            cyc(); nic_sel = 1'b0;
            for (int k = 1; k <= 16; k++) begin
                smp();
                chk("tmo_busy", o_busy, 1);
                chk("tmo_noack", o_ack, 0);
                cyc();
            end
            smp();
            chk("tmo_ack", o_ack, 1);
            chk("tmo_err", o_err, 1);
            exp_cnt0++;
            cyc(); smp();
            chk("tmo_errcnt", o_err_cnt, exp_cnt0);
        end
        // Hit on the limit cycle wins over the timeout
        cyc(); nic_sel = 1'b1; addr_sel = 2'd1; smp();
        cyc(); nic_sel = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            smp(); cyc();
        end
        ack[1] = 1'b1; rdata[1] = 32'hCAFEF00D; q0.push_back({1'b0, 32'hCAFEF00D}); smp();
        chk("tmo_edge_ack", o_ack, 1);
        chk("tmo_edge_err", o_err, 0);
        cyc(); ack = '0; smp();
        chk("tmo_edge_after", o_ack, 0);
        chk("tmo_edge_cnt", o_err_cnt, exp_cnt0);
`else
        // Without timeout, WAIT persists indefinitely
        cyc(); nic_sel = 1'b1; addr_sel = 2'd1; smp();
        cyc(); nic_sel = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            smp();
            chk("notmo_busy", o_busy, 1);
            cyc();
        end
        ack[1] = 1'b1; rdata[1] = 32'hCAFEF00D; q0.push_back({1'b0, 32'hCAFEF00D}); smp();
        chk("notmo_ack", o_ack, 1);
        cyc(); ack = '0; smp();
        chk("notmo_errcnt", o_err_cnt, 0);
`endif

        // Out-of-range on a 3-slave instance
        cyc(); nic_sel3 = 1'b1; addr_sel3 = 2'd3; q3.push_back({1'b1, 32'h0}); smp();
        chk("oor_sel", o_slave_sel3, 0);
        chk("oor_busy_c0", o_busy3, 0);
        cyc(); nic_sel3 = 1'b0; smp();
        chk("oor_ack", o_ack3, 1);
        chk("oor_err", o_err3, 1);
        chk("oor_busy_c1", o_busy3, 1);
        exp_cnt3++;
        cyc(); smp();
        chk("oor_errcnt", o_err_cnt3, exp_cnt3);

        // In-range read on the 3-slave instance
        cyc(); nic_sel3 = 1'b1; addr_sel3 = 2'd2; smp();
        chk("d3_sel", o_slave_sel3, 3'b100);
        cyc(); nic_sel3 = 1'b0; smp();
        cyc(); ack[2] = 1'b1; rdata[2] = 32'h0000ABCD; q3.push_back({1'b0, 32'h0000ABCD}); smp();
        chk("d3_ack", o_ack3, 1);
        cyc(); ack = '0;

        // Error counter saturation
        for (int n = 1; n < 300; n++) begin
            nic_sel3 = 1'b1; addr_sel3 = 2'd3; q3.push_back({1'b1, 32'h0});
            cyc(); nic_sel3 = 1'b0;
            cyc();
            exp_cnt3 = (exp_cnt3 < 255) ? exp_cnt3 + 1 : 255;
            if (n == 200) begin
                smp();
                chk("sat_mid", o_err_cnt3, exp_cnt3);
            end
        end
        smp();
        chk("sat_final", o_err_cnt3, 255);

        // Reset during WAIT aborts; a late slave ack is ignored
        cyc(); nic_sel = 1'b1; addr_sel = 2'd0; smp();
        cyc(); nic_sel = 1'b0; smp();
        chk("rstw_busy_c1", o_busy, 1);
        cyc(); rst_n = 1'b0; smp();
        chk("rstw_busy_c2", o_busy, 0);
        chk("rstw_ack_c2", o_ack, 0);
        cyc(); rst_n = 1'b1; ack[0] = 1'b1; rdata[0] = 32'h0F0F0F0F; smp();
        chk("rstw_ack_c3", o_ack, 0);
        chk("rstw_busy_c3", o_busy, 0);
        chk("rstw_cnt3", o_err_cnt3, 0);
        cyc(); ack = '0;
        nic_sel = 1'b1; addr_sel = 2'd0; smp();
        chk("rstw_newsel", o_slave_sel, 4'b0001);
        cyc(); nic_sel = 1'b0; ack[0] = 1'b1; rdata[0] = 32'h77777777;
        q0.push_back({1'b0, 32'h77777777}); smp();
        chk("rstw_newack", o_ack, 1);
        cyc(); ack = '0; smp();

        chk("sb0_empty", q0.size(), 0);
        chk("sb3_empty", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
